prbs_gen_chk: RTL and testbench
===============================

Name: prbs_gen_chk

Overview:
- Parametrised pseudo-random bit-sequence generator and checker pair.
- Successor to the fixed single-bit PRBS31 source: runtime-selectable polynomial (PRBS7/15/23/31), OUT_W bits per clock, seed load, error injection.
- Adds a receive-side checker with a lock state machine and a saturating bit-error counter.
- Used for on-chip loopback and link BIST; gen_out drives pads or an internal loop, and chk_in samples them.

Parameters:
- OUT_W, 8, bits generated and checked per valid cycle (1..8).
- ERR_W, 16, width of the bit-error counter.
- LOCK_WORDS, 4, consecutive clean words required in VERIFY before LOCKED.
- LOSS_WORDS, 4, consecutive errored words in LOCKED before returning to SEARCH.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous reset, active-high: rst_n=1 at a rising edge resets the block.
- en  in  1  generator advances OUT_W bits this cycle.
- mode  in  2  00 PRBS7 (n=7,t=6), 01 PRBS15 (15,14), 10 PRBS23 (23,18), 11 PRBS31 (31,28); sampled only on seed_load.
- seed_load  in  1  load seed and mode into the generator; force the checker to SEARCH.
- seed  in  31  generator seed; bits above n-1 are ignored.
- inj_err  in  1  invert one bit of the word produced this cycle.
- gen_out  out  OUT_W  generated word, MSB = earliest bit.
- gen_valid  out  1  gen_out holds a new word.
- chk_in  in  OUT_W  received word, MSB = earliest bit.
- chk_valid  in  1  chk_in valid this cycle.
- clr_cnt  in  1  clear err_count and err_sat.
- chk_locked  out  1  checker in LOCKED.
- err_count  out  ERR_W  accumulated bit errors while LOCKED, saturating.
- err_sat  out  1  sticky flag: err_count reached all-ones.

Behaviour:
- Recurrence: x_m = x_(m-n) XOR x_(m-t).
- Generator state s[30:0] uses only bits [n-1:0]; bits above n-1 are held 0.
  - One serial step: output s[n-1], then s <= {s[n-2:0], s[n-1]^s[t-1]}.
  - One en cycle performs OUT_W steps; the first bit goes to gen_out[OUT_W-1].
- Timing: gen_out and gen_valid are registered, so latency is 1 cycle.
  - gen_valid is en delayed by one cycle.
  - gen_out holds its value when en=0.
- inj_err: flips gen_out[OUT_W-1] of the word produced that cycle only; the LFSR state is unaffected. It is ignored when en=0.
- seed_load: s <= seed masked to n bits, and the latched mode is updated.
  - A masked value of 0 loads 1 instead.
  - If seed_load and en are asserted together, seed_load wins and no word is produced.
- Reset: s=1, mode_q=11, gen_out=0, gen_valid=0, checker state SEARCH, chk_locked=0, err_count=0, err_sat=0.
- Checker history h[30:0], with h[0] = newest bit.
  - Predicted next bit = h[n-1]^h[t-1].
  - Per valid word, bits are processed MSB first. Only cycles with chk_valid=1 act.
- SEARCH:
  - Shift received bits into h.
  - Once at least n bits have been received since entry AND h[n-1:0] is non-zero, go to VERIFY at the word boundary.
  - An all-zero history stays in SEARCH, so a stuck-at-0 link never locks.
- VERIFY:
  - Shift the predicted bits into h and compare each with the received bit.
  - Any mismatch: go to SEARCH.
  - LOCK_WORDS consecutive clean words: go to LOCKED.
- LOCKED:
  - chk_locked=1; h self-runs on the predicted bits.
  - err_count += popcount(received XOR predicted), saturating at 2^ERR_W-1, and err_sat is set on reaching that value.
  - LOSS_WORDS consecutive words with one or more errors: go to SEARCH. chk_locked drops at the same edge; err_count is retained.
  - A clean word resets the loss run.
- clr_cnt: the same cycle as an errored word, clear wins and that word's errors are dropped. It does not affect lock state.
- seed_load from any checker state: checker goes to SEARCH with h cleared and its counters reset; err_count is retained.
- chk_locked is registered and reflects the state after the edge.
- Reset asserted mid-operation returns every register to its reset value at that edge.

Test Plan:
- Reset, then mode=00, seed=1, seed_load, then en=1 for 2 cycles (OUT_W=8) -> gen_out=8'h02, then 8'h0C.
- PRBS7 with OUT_W=1, en held high -> the gen_out bit stream repeats with period exactly 127 and contains 64 ones per period.
- Loopback (chk_in=gen_out, chk_valid=gen_valid), mode=11, OUT_W=8 -> chk_locked rises after 4 SEARCH words + 4 VERIFY words; err_count stays 0 over 10k words.
- While locked, pulse inj_err 3 times in separate cycles -> err_count=3, chk_locked stays 1, gen LFSR sequence unchanged otherwise.
- While locked, force chk_in to 8'h00 -> chk_locked falls after 4 errored words; the checker stays in SEARCH indefinitely, never relocking on zeros.
- ERR_W=4, inject 20 errors while locked -> err_count=15, err_sat=1. Then clr_cnt together with one more injected error -> err_count=0, err_sat=0.

Source files
------------

// File: rtl/prbs_gen_chk.sv
// PRBS generator / checker pair for loopback and link BIST.
// Generator emits OUT_W bits per enabled cycle (MSB = earliest bit) from a
// runtime-selectable PRBS7/15/23/31 LFSR. The checker self-synchronises to the
// received stream, tracks lock, and counts bit errors while locked.
// Note: rst_n is an active-high synchronous reset despite its name.
module prbs_gen_chk #(
  parameter int OUT_W      = 8,
  parameter int ERR_W      = 16,
  parameter int LOCK_WORDS = 4,
  parameter int LOSS_WORDS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             seed_load,
  input  logic [30:0]      seed,
  input  logic             inj_err,
  output logic [OUT_W-1:0] gen_out,
  output logic             gen_valid,
  input  logic [OUT_W-1:0] chk_in,
  input  logic             chk_valid,
  input  logic             clr_cnt,
  output logic             chk_locked,
  output logic [ERR_W-1:0] err_count,
  output logic             err_sat
);

  localparam int NERR_W  = $clog2(OUT_W + 1);
  localparam int RUN_MAX = (LOCK_WORDS > LOSS_WORDS) ? LOCK_WORDS : LOSS_WORDS;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);
  localparam logic [RUN_W-1:0] LOCK_LAST = RUN_W'(LOCK_WORDS - 1);
  localparam logic [RUN_W-1:0] LOSS_LAST = RUN_W'(LOSS_WORDS - 1);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} chk_state_t;

  // Polynomial length n for each mode
  function automatic logic [4:0] poly_n(input logic [1:0] m);
    case (m)
      2'b00:   poly_n = 5'd7;
      2'b01:   poly_n = 5'd15;
      2'b10:   poly_n = 5'd23;
      default: poly_n = 5'd31;
    endcase
  endfunction

  // Tap position t for each mode
  function automatic logic [4:0] poly_t(input logic [1:0] m);
    case (m)
      2'b00:   poly_t = 5'd6;
      2'b01:   poly_t = 5'd14;
      2'b10:   poly_t = 5'd18;
      default: poly_t = 5'd28;
    endcase
  endfunction

  // Mask keeping only state bits [n-1:0]
  function automatic logic [30:0] poly_mask(input logic [4:0] n);
    poly_mask = 31'h7FFF_FFFF >> (5'd31 - n);
  endfunction

  // Saturating add of one word's error count onto the accumulator
  function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] a,
                                               input logic [NERR_W-1:0] b);
    logic [ERR_W+NERR_W-1:0] s;
    s = {{NERR_W{1'b0}}, a} + {{ERR_W{1'b0}}, b};
    if (s > {{NERR_W{1'b0}}, {ERR_W{1'b1}}})
      sat_add = '1;
    else
      sat_add = s[ERR_W-1:0];
  endfunction

  logic [1:0]       mode_q;
  logic [30:0]      s_q;
  logic [30:0]      s_nxt;
  logic [30:0]      ld_seed;
  logic [OUT_W-1:0] g_word;
  logic [OUT_W-1:0] inj_vec;
  logic [4:0]       g_n, g_t;
  logic [30:0]      g_mask;
  logic             g_fb;

  chk_state_t       state_q, state_d;
  logic [30:0]      h_q, h_d, h_shift, h_pred;
  logic [5:0]       bits_q, bits_d, bits_add;
  logic [RUN_W-1:0] run_q, run_d;
  logic [NERR_W-1:0] nerr, err_add;
  logic [ERR_W-1:0] err_nxt;
  logic [4:0]       c_n, c_t;
  logic [30:0]      c_mask;
  logic             pb;

  // Generator: advance the LFSR OUT_W serial steps and form the output word
  always_comb begin
    g_n     = poly_n(mode_q);
    g_t     = poly_t(mode_q);
    g_mask  = poly_mask(g_n);
    s_nxt   = s_q;
    g_word  = '0;
    g_fb    = 1'b0;
    inj_vec = '0;
    inj_vec[OUT_W-1] = inj_err;
    for (int i = OUT_W - 1; i >= 0; i--) begin
      g_word[i] = s_nxt[g_n - 5'd1];
      g_fb      = s_nxt[g_n - 5'd1] ^ s_nxt[g_t - 5'd1];
      s_nxt     = {s_nxt[29:0], g_fb} & g_mask;
    end
    ld_seed = seed & poly_mask(poly_n(mode));
    if (ld_seed == 31'd0)
      ld_seed = 31'd1;
  end

  // Generator stage: LFSR state, latched mode and registered output word
  always_ff @(posedge clk) begin
    if (rst_n) begin
      s_q       <= 31'd1;
      mode_q    <= 2'b11;
      gen_out   <= '0;
      gen_valid <= 1'b0;
    end else if (seed_load) begin
      s_q       <= ld_seed;
      mode_q    <= mode;
      gen_valid <= 1'b0;
    end else begin
      gen_valid <= en;
      if (en) begin
        s_q     <= s_nxt;
        gen_out <= g_word ^ inj_vec;
      end
    end
  end

  // Checker datapath: shift received bits and run the predictor over one word
  always_comb begin
    c_n     = poly_n(mode_q);
    c_t     = poly_t(mode_q);
    c_mask  = poly_mask(c_n);
    h_shift = h_q;
    h_pred  = h_q;
    nerr    = '0;
    pb      = 1'b0;
    for (int i = OUT_W - 1; i >= 0; i--) begin
      pb      = h_pred[c_n - 5'd1] ^ h_pred[c_t - 5'd1];
      nerr    = nerr + NERR_W'(pb ^ chk_in[i]);
      h_pred  = {h_pred[29:0], pb};
      h_shift = {h_shift[29:0], chk_in[i]};
    end
    bits_add = bits_q + 6'(OUT_W);
  end

  // Checker lock FSM: next state, history, run counters and errors to add
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    bits_d  = bits_q;
    run_d   = run_q;
    err_add = '0;
    if (seed_load) begin
      state_d = SEARCH;
      h_d     = '0;
      bits_d  = '0;
      run_d   = '0;
    end else if (chk_valid) begin
      case (state_q)
        SEARCH: begin
          h_d    = h_shift;
          bits_d = (bits_add > 6'd31) ? 6'd31 : bits_add;
          if ((bits_add >= {1'b0, c_n}) && ((h_shift & c_mask) != 31'd0)) begin
            state_d = VERIFY;
            bits_d  = '0;
            run_d   = '0;
          end
        end
        VERIFY: begin
          h_d = h_pred;
          if (nerr != '0) begin
            state_d = SEARCH;
            bits_d  = '0;
            run_d   = '0;
          end else if (run_q == LOCK_LAST) begin
            state_d = LOCKED;
            run_d   = '0;
          end else begin
            run_d = run_q + 1'b1;
          end
        end
        LOCKED: begin
          h_d     = h_pred;
          err_add = nerr;
          if (nerr != '0) begin
            if (run_q == LOSS_LAST) begin
              state_d = SEARCH;
              bits_d  = '0;
              run_d   = '0;
            end else begin
              run_d = run_q + 1'b1;
            end
          end else begin
            run_d = '0;
          end
        end
        default: begin
          state_d = SEARCH;
          bits_d  = '0;
          run_d   = '0;
        end
      endcase
    end
    err_nxt = sat_add(err_count, err_add);
  end

  // Checker state register; chk_locked reflects the state after the edge
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= SEARCH;
      h_q        <= '0;
      bits_q     <= '0;
      run_q      <= '0;
      chk_locked <= 1'b0;
    end else begin
      state_q    <= state_d;
      h_q        <= h_d;
      bits_q     <= bits_d;
      run_q      <= run_d;
      chk_locked <= (state_d == LOCKED);
    end
  end

  // Error accumulator: clear has priority over the errors of the same word
  always_ff @(posedge clk) begin
    if (rst_n) begin
      err_count <= '0;
      err_sat   <= 1'b0;
    end else if (clr_cnt) begin
      err_count <= '0;
      err_sat   <= 1'b0;
    end else begin
      err_count <= err_nxt;
      err_sat   <= err_sat | (&err_nxt);
    end
  end

endmodule

// File: tb/tb_prbs_gen_chk.sv
// Bench for prbs_gen_chk: directed generator vectors, loopback lock/error
// sequences, saturation/clear corner case and PRBS7 period check.
module tb_prbs_gen_chk;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: OUT_W=8, ERR_W=16
  logic       a_en, a_sl, a_inj, a_clr, a_force;
  logic [1:0] a_mode;
  logic [30:0] a_seed;
  logic [7:0] a_gen_out, a_chk_in;
  logic       a_gen_valid, a_locked, a_sat;
  logic [15:0] a_cnt;
  assign a_chk_in = a_force ? 8'h00 : a_gen_out;

  // Instance B: OUT_W=8, ERR_W=4
  logic       b_en, b_sl, b_inj, b_clr;
  logic [1:0] b_mode;
  logic [30:0] b_seed;
  logic [7:0] b_gen_out;
  logic       b_gen_valid, b_locked, b_sat;
  logic [3:0] b_cnt;

  // Instance C: OUT_W=1, ERR_W=16
  logic       c_en, c_sl;
  logic [1:0] c_mode;
  logic [30:0] c_seed;
  logic [0:0] c_gen_out;
  logic       c_gen_valid, c_locked, c_sat;
  logic [15:0] c_cnt;

  prbs_gen_chk #(.OUT_W(8), .ERR_W(16), .LOCK_WORDS(4), .LOSS_WORDS(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(a_en), .mode(a_mode), .seed_load(a_sl),
    .seed(a_seed), .inj_err(a_inj), .gen_out(a_gen_out), .gen_valid(a_gen_valid),
    .chk_in(a_chk_in), .chk_valid(a_gen_valid), .clr_cnt(a_clr),
    .chk_locked(a_locked), .err_count(a_cnt), .err_sat(a_sat));

  prbs_gen_chk #(.OUT_W(8), .ERR_W(4), .LOCK_WORDS(4), .LOSS_WORDS(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(b_en), .mode(b_mode), .seed_load(b_sl),
    .seed(b_seed), .inj_err(b_inj), .gen_out(b_gen_out), .gen_valid(b_gen_valid),
    .chk_in(b_gen_out), .chk_valid(b_gen_valid), .clr_cnt(b_clr),
    .chk_locked(b_locked), .err_count(b_cnt), .err_sat(b_sat));

  prbs_gen_chk #(.OUT_W(1), .ERR_W(16), .LOCK_WORDS(4), .LOSS_WORDS(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(c_en), .mode(c_mode), .seed_load(c_sl),
    .seed(c_seed), .inj_err(1'b0), .gen_out(c_gen_out), .gen_valid(c_gen_valid),
    .chk_in(c_gen_out), .chk_valid(c_gen_valid), .clr_cnt(1'b0),
    .chk_locked(c_locked), .err_count(c_cnt), .err_sat(c_sat));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: window of the next n output bits, w[0] = next bit out
  logic [30:0] mdl_w;
  int mdl_n, mdl_t;

  task automatic mdl_load(input logic [1:0] m, input logic [30:0] sd);
    logic any;
    case (m)
      2'b00:   begin mdl_n = 7;  mdl_t = 6;  end
      2'b01:   begin mdl_n = 15; mdl_t = 14; end
      2'b10:   begin mdl_n = 23; mdl_t = 18; end
      default: begin mdl_n = 31; mdl_t = 28; end
    endcase
    mdl_w = '0;
    any = 1'b0;
    for (int i = 0; i < mdl_n; i++) begin
      mdl_w[i] = sd[mdl_n-1-i];
      any = any | sd[mdl_n-1-i];
    end
    if (!any) mdl_w[mdl_n-1] = 1'b1;
  endtask

  task automatic mdl_next(input int nbits, output logic [7:0] word);
    logic b, nb;
    word = 8'h00;
    for (int k = 0; k < nbits; k++) begin
      b  = mdl_w[0];
      nb = mdl_w[0] ^ mdl_w[mdl_n-mdl_t];
      for (int j = 0; j < mdl_n - 1; j++) mdl_w[j] = mdl_w[j+1];
      mdl_w[mdl_n-1] = nb;
      word = {word[6:0], b};
    end
  endtask

  typedef struct packed {
    logic        sl;
    logic [1:0]  mode;
    logic [30:0] seed;
    logic        en;
    logic        inj;
    logic [7:0]  exp_out;
    logic        exp_vld;
  } vec_t;

  vec_t vecs [18];

  initial begin
    logic [7:0] w, prev_w;
    logic [253:0] cbits;
    int mism, ldrop, run, exp_err, ones;
    logic exp_lock;

    vecs[0]  = '{1'b0, 2'd0, 31'h0,        1'b1, 1'b0, 8'h00, 1'b1};
    vecs[1]  = '{1'b0, 2'd0, 31'h0,        1'b1, 1'b0, 8'h00, 1'b1};
    vecs[2]  = '{1'b0, 2'd0, 31'h0,        1'b1, 1'b0, 8'h00, 1'b1};
    vecs[3]  = '{1'b0, 2'd0, 31'h0,        1'b1, 1'b0, 8'h02, 1'b1};
    vecs[4]  = '{1'b1, 2'd0, 31'h1,        1'b0, 1'b0, 8'h02, 1'b0};
    vecs[5]  = '{1'b0, 2'd0, 31'h0,        1'b1, 1'b0, 8'h02, 1'b1};
    vecs[6]  = '{1'b0, 2'd0, 31'h0,        1'b1, 1'b0, 8'h0C, 1'b1};
    vecs[7]  = '{1'b0, 2'd0, 31'h0,        1'b0, 1'b0, 8'h0C, 1'b0};
    vecs[8]  = '{1'b0, 2'd0, 31'h0,        1'b1, 1'b1, 8'hA8, 1'b1};
    vecs[9]  = '{1'b1, 2'd0, 31'h7FFFFF80, 1'b1, 1'b0, 8'hA8, 1'b0};
    vecs[10] = '{1'b0, 2'd0, 31'h0,        1'b1, 1'b0, 8'h02, 1'b1};
    vecs[11] = '{1'b1, 2'd1, 31'h7FFF8001, 1'b0, 1'b0, 8'h02, 1'b0};
    vecs[12] = '{1'b0, 2'd0, 31'h0,        1'b1, 1'b0, 8'h00, 1'b1};
    vecs[13] = '{1'b0, 2'd0, 31'h0,        1'b1, 1'b0, 8'h02, 1'b1};
    vecs[14] = '{1'b1, 2'd3, 31'h40000000, 1'b0, 1'b0, 8'h02, 1'b0};
    vecs[15] = '{1'b0, 2'd0, 31'h0,        1'b1, 1'b0, 8'h80, 1'b1};
    vecs[16] = '{1'b0, 2'd0, 31'h0,        1'b1, 1'b0, 8'h00, 1'b1};
    vecs[17] = '{1'b0, 2'd0, 31'h0,        1'b0, 1'b1, 8'h00, 1'b0};

    a_en = 0; a_sl = 0; a_inj = 0; a_clr = 0; a_force = 0; a_mode = 0; a_seed = 0;
    b_en = 0; b_sl = 0; b_inj = 0; b_clr = 0; b_mode = 0; b_seed = 0;
    c_en = 0; c_sl = 0; c_mode = 0; c_seed = 0;

    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gen_out", 32'(a_gen_out), 32'h0);
    check("rst_gen_valid", 32'(a_gen_valid), 32'h0);
    check("rst_locked", 32'(a_locked), 32'h0);
    check("rst_err_count", 32'(a_cnt), 32'h0);
    check("rst_err_sat", 32'(a_sat), 32'h0);
    rst_n = 1'b0;

    // Directed generator vectors
    for (int i = 0; i < 18; i++) begin
      a_sl = vecs[i].sl; a_mode = vecs[i].mode; a_seed = vecs[i].seed;
      a_en = vecs[i].en; a_inj = vecs[i].inj;
      @(posedge clk); #1;
      check($sformatf("vec%0d_gen_out", i), 32'(a_gen_out), 32'(vecs[i].exp_out));
      check($sformatf("vec%0d_gen_valid", i), 32'(a_gen_valid), 32'(vecs[i].exp_vld));
    end
    a_sl = 0; a_en = 0; a_inj = 0;

    // Loopback acquisition on PRBS31
    a_mode = 2'b11; a_seed = 31'h2468ACE1; a_sl = 1;
    @(posedge clk); #1;
    a_sl = 0;
    mdl_load(2'b11, 31'h2468ACE1);
    a_en = 1;
    mism = 0;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(posedge clk); #1;
      mdl_next(8, w);
      if (a_gen_out !== w) mism++;
      if (cyc == 8) check("lock_not_before_8_words", 32'(a_locked), 32'h0);
      if (cyc == 9) check("lock_after_8_words", 32'(a_locked), 32'h1);
    end
    check("acq_gen_stream", 32'(mism), 32'h0);

    // Long clean run
    mism = 0; ldrop = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(posedge clk); #1;
      mdl_next(8, w);
      if (a_gen_out !== w) mism++;
      if (a_locked !== 1'b1) ldrop++;
    end
    check("long_gen_stream", 32'(mism), 32'h0);
    check("long_lock_drops", 32'(ldrop), 32'h0);
    check("long_err_count", 32'(a_cnt), 32'h0);

    // Three single-bit injections in separate cycles
    mism = 0; ldrop = 0;
    for (int k = 0; k < 3; k++) begin
      a_inj = 1;
      @(posedge clk); #1;
      a_inj = 0;
      mdl_next(8, w);
      check($sformatf("inj%0d_word", k), 32'(a_gen_out), 32'(w ^ 8'h80));
      if (a_locked !== 1'b1) ldrop++;
      for (int j = 0; j < 3; j++) begin
        @(posedge clk); #1;
        mdl_next(8, w);
        if (a_gen_out !== w) mism++;
        if (a_locked !== 1'b1) ldrop++;
      end
    end
    check("inj_gen_stream", 32'(mism), 32'h0);
    check("inj_lock_held", 32'(ldrop), 32'h0);
    check("inj_err_count", 32'(a_cnt), 32'd3);

    // Stuck-at-zero link: lock lost after 4 errored words, never regained
    prev_w = w;
    a_force = 1;
    exp_err = 3; run = 0; exp_lock = 1'b1; mism = 0; ldrop = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(posedge clk); #1;
      if (exp_lock) begin
        exp_err += $countones(prev_w);
        if (prev_w != 8'h00) run++; else run = 0;
        if (run == 4) exp_lock = 1'b0;
      end
      mdl_next(8, w);
      if (a_gen_out !== w) mism++;
      prev_w = w;
      if (cyc < 8)
        check($sformatf("zero_lock_c%0d", cyc), 32'(a_locked), 32'(exp_lock));
      else if (a_locked !== 1'b0)
        ldrop++;
    end
    check("zero_never_relock", 32'(ldrop), 32'h0);
    check("zero_gen_stream", 32'(mism), 32'h0);
    check("zero_err_count", 32'(a_cnt), 32'(exp_err));

    // Reset asserted mid-operation
    a_force = 0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_gen_out", 32'(a_gen_out), 32'h0);
    check("midrst_gen_valid", 32'(a_gen_valid), 32'h0);
    check("midrst_locked", 32'(a_locked), 32'h0);
    check("midrst_err_count", 32'(a_cnt), 32'h0);
    check("midrst_err_sat", 32'(a_sat), 32'h0);
    rst_n = 1'b0;
    a_en = 0;

    // ERR_W=4 saturation and clear-with-error
    b_mode = 2'b11; b_seed = 31'h13579BDF; b_sl = 1;
    @(posedge clk); #1;
    b_sl = 0; b_en = 1;
    repeat (12) @(posedge clk);
    #1;
    check("b_locked", 32'(b_locked), 32'h1);
    for (int k = 1; k <= 20; k++) begin
      b_inj = 1;
      @(posedge clk); #1;
      b_inj = 0;
      repeat (2) @(posedge clk);
      #1;
      if (k == 14) begin
        check("b_cnt_14", 32'(b_cnt), 32'd14);
        check("b_sat_14", 32'(b_sat), 32'h0);
      end
      if (k == 15) begin
        check("b_cnt_15", 32'(b_cnt), 32'd15);
        check("b_sat_15", 32'(b_sat), 32'h1);
      end
    end
    check("b_cnt_20", 32'(b_cnt), 32'd15);
    check("b_sat_20", 32'(b_sat), 32'h1);
    check("b_locked_20", 32'(b_locked), 32'h1);
    b_inj = 1;
    @(posedge clk); #1;
    b_inj = 0; b_clr = 1;
    @(posedge clk); #1;
    b_clr = 0;
    check("b_clr_cnt", 32'(b_cnt), 32'h0);
    check("b_clr_sat", 32'(b_sat), 32'h0);
    @(posedge clk); #1;
    check("b_clr_cnt_after", 32'(b_cnt), 32'h0);
    check("b_clr_locked", 32'(b_locked), 32'h1);
    b_en = 0;

    // PRBS7 period with OUT_W=1
    c_mode = 2'b00; c_seed = 31'h55; c_sl = 1;
    @(posedge clk); #1;
    c_sl = 0; c_en = 1;
    mdl_load(2'b00, 31'h55);
    mism = 0;
    for (int i = 0; i < 254; i++) begin
      @(posedge clk); #1;
      cbits[i] = c_gen_out[0];
      mdl_next(1, w);
      if (c_gen_out[0] !== w[0]) mism++;
    end
    c_en = 0;
    check("c_bit_stream", 32'(mism), 32'h0);
    mism = 0; ones = 0;
    for (int i = 0; i < 127; i++) begin
      if (cbits[i] !== cbits[i+127]) mism++;
      if (cbits[i] === 1'b1) ones++;
    end
    check("c_period_127", 32'(mism), 32'h0);
    check("c_ones_per_period", 32'(ones), 32'd64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
